// File: rtl/max_pool_3_engine.sv
// 2x2 stride-2 signed max pool over a CH x IN_H x IN_W word-per-element BRAM.
// One output every 6 cycles: four window reads, one drain cycle for read latency, one write.
module max_pool_3_engine #(
  parameter int          IN_W     = 8,
  parameter int          IN_H     = 8,
  parameter int          CH       = 64,
  parameter logic [31:0] SRC_BASE = 32'h0,
  parameter logic [31:0] DST_BASE = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] src_addr,
  output logic        src_en,
  input  logic [31:0] src_dout,
  output logic [31:0] dst_addr,
  output logic [31:0] dst_din,
  output logic        dst_en,
  output logic [3:0]  dst_we
);

  localparam int          OW     = IN_W / 2;
  localparam int          OH     = IN_H / 2;
  localparam logic [31:0] OW_M1  = 32'(OW - 1);
  localparam logic [31:0] OH_M1  = 32'(OH - 1);
  localparam logic [31:0] CH_M1  = 32'(CH - 1);
  localparam logic [31:0] W32    = 32'(IN_W);
  localparam logic [31:0] SPLANE = 32'(IN_H * IN_W);
  localparam logic [31:0] DPLANE = 32'(OH * OW);

  typedef enum logic [2:0] {IDLE, RD, LAST, WR, DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  k;
  logic [31:0] ox, oy, c;
  logic [31:0] max_q;
  logic [31:0] src_idx, dst_idx;
  logic        last_out;

  assign last_out = (ox == OW_M1) && (oy == OH_M1) && (c == CH_M1);

  // k[1] is the row offset dy, k[0] the column offset dx inside the window
  assign src_idx = c * SPLANE + ((oy << 1) + {31'b0, k[1]}) * W32 + (ox << 1) + {31'b0, k[0]};
  assign dst_idx = c * DPLANE + oy * 32'(OW) + ox;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RD;
      RD:      if (k == 2'd3) state_nxt = LAST;
      LAST:    state_nxt = WR;
      WR:      state_nxt = last_out ? DONE : RD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    done     = (state == DONE);
    src_en   = 1'b0;
    src_addr = 32'h0;
    dst_en   = 1'b0;
    dst_we   = 4'h0;
    dst_addr = 32'h0;
    dst_din  = 32'h0;
    case (state)
      RD: begin
        src_en   = 1'b1;
        src_addr = SRC_BASE + (src_idx << 2);
      end
      WR: begin
        dst_en   = 1'b1;
        dst_we   = 4'hF;
        dst_addr = DST_BASE + (dst_idx << 2);
        dst_din  = max_q;
      end
      default: ;
    endcase
  end

  // Window / output counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k  <= 2'd0;
      ox <= 32'h0;
      oy <= 32'h0;
      c  <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          k  <= 2'd0;
          ox <= 32'h0;
          oy <= 32'h0;
          c  <= 32'h0;
        end
        RD: k <= k + 2'd1;
        WR: if (!last_out) begin
          k <= 2'd0;
          if (ox == OW_M1) begin
            ox <= 32'h0;
            if (oy == OH_M1) begin
              oy <= 32'h0;
              c  <= c + 32'h1;
            end else begin
              oy <= oy + 32'h1;
            end
          end else begin
            ox <= ox + 32'h1;
          end
        end
        default: ;
      endcase
    end
  end

  // src_dout trails src_en by one cycle, so the k=0 word lands while k=1 is issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= 32'h0;
    end else if (state == RD && k == 2'd1) begin
      max_q <= src_dout;
    end else if ((state == RD && k != 2'd0) || state == LAST) begin
      if ($signed(src_dout) > $signed(max_q)) max_q <= src_dout;
    end
  end

endmodule

// File: doc/max_pool_3_engine.md
MAX_POOL_3_ENGINE -- requirements
Module: max_pool_3_engine

Interface
REQ-001 Parameters SHALL be IN_W (8, input width), IN_H (8, input height), CH (64, channels), SRC_BASE (32'h0, source byte base), DST_BASE (32'h0, destination byte base).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  run request, sampled in IDLE only.
REQ-006 busy  out  1  high in every state except IDLE.
REQ-007 done  out  1  one-cycle completion pulse.
REQ-008 src_addr  out  32  byte address into conv_3 output BRAM.
REQ-009 src_en  out  1  source read enable.
REQ-010 src_dout  in  32  source read data, signed, valid one cycle after src_en.
REQ-011 dst_addr  out  32  byte address into max_pool_3 BRAM.
REQ-012 dst_din  out  32  pooled value.
REQ-013 dst_en  out  1  destination enable.
REQ-014 dst_we  out  4  byte write enables, 4'hF on write, else 4'h0.

Function
REQ-015 The block SHALL compute a 2x2, stride-2 signed max pool: (IN_H x IN_W x CH) in, (IN_H/2 x IN_W/2 x CH) out, one 32-bit value per word.
REQ-016 The source element (c,y,x) SHALL be at SRC_BASE + 4*(c*IN_H*IN_W + y*IN_W + x).
REQ-017 The output (c,oy,ox) SHALL be at DST_BASE + 4*(c*(IN_H/2)*(IN_W/2) + oy*(IN_W/2) + ox).
REQ-018 Output order SHALL be ox fastest, then oy, then c.
REQ-019 FSM states SHALL be IDLE, RD, LAST, WR, DONE.
REQ-020 IDLE with start=1 SHALL go to RD with k=0; start=0 stays in IDLE.
REQ-021 In RD, k=0..3 SHALL select window offset (dy,dx) = (0,0),(0,1),(1,0),(1,1), with src_en=1 and the matching src_addr.
REQ-022 RD SHALL go to LAST after k=3.
REQ-023 At RD k=1 the max register SHALL load src_dout.
REQ-024 At RD k=2, RD k=3 and LAST, the max register SHALL take the signed maximum of itself and src_dout.
REQ-025 WR SHALL last one cycle with dst_en=1, dst_we=4'hF, dst_din=max, and dst_addr per REQ-017.
REQ-026 WR SHALL go to DONE after the last output, else to RD with k=0 and counters advanced.
REQ-027 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-028 Each output SHALL take 6 cycles.
REQ-029 With defaults, the done cycle SHALL be 1024*6+1 = 6145 cycles after the start-sampling edge.
REQ-030 src_en, dst_en and dst_we SHALL be 0 in all states other than those stated above.
REQ-031 start while busy SHALL be ignored with no restart; start held high through DONE SHALL begin a new run from IDLE.
REQ-032 The comparison SHALL be full 32-bit two's complement, with no saturation or truncation.

Reset
REQ-033 While rst_n=0, the FSM SHALL be IDLE and all counters and the max register SHALL be 0.
REQ-034 While rst_n=0, busy, done, src_en, dst_en and all address and data outputs SHALL be 0, and dst_we SHALL be 4'h0.
REQ-035 Reset asserted mid-run SHALL abort immediately, with no partial write after assertion; the next start SHALL begin from output 0.

Verification
REQ-036 Reset: hold rst_n=0 for 3 cycles -> all outputs 0, busy=0; release -> still IDLE.
REQ-037 Ramp: src word i = i, start pulse -> dst word 0 = 9, word 1 = 11, word 16 = 73, 1024 writes total, done at cycle 6145, busy low the cycle after done.
REQ-038 Max position: window values with the max placed in turn at (0,0),(0,1),(1,0),(1,1), e.g. {40,1,2,3} -> 40 for each placement.
REQ-039 Signed data: {-5,-3,-9,-7} -> 32'hFFFFFFFD; all 32'h80000000 -> 32'h80000000; {32'h7FFFFFFF,-1,0,1} -> 32'h7FFFFFFF.
REQ-040 Start pulses at cycles 10 and 3000 of a run -> single run, single done pulse, 1024 writes.
REQ-041 rst_n low during output 100's RD -> no dst_en until the next start; rerun matches the ramp result exactly.
